// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO read-side round-robin arbiter.
//   arb_state_t : arbiter FSM encoding (IDLE, BURST)
//   ch_width()  : channel index width, never narrower than one bit
package fifo_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_t;

    function automatic int ch_width(input int n);
        if (n <= 1) begin
            return 1;
        end
        return $clog2(n);
    endfunction

endpackage

// File: rtl/fifo_read_interface_arbiter_rr_next_select.sv
// Rotating priority finder: reports the first set request bit at or after
// start_i, wrapping past the top back to bit 0.
//   req_i   : request vector, one bit per channel
//   start_i : index scanned first
//   found_o : at least one request bit is set
//   idx_o   : index of the winning request (0 when nothing is found)
module rr_next_select #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] req_i,
    input  logic [W-1:0] start_i,
    output logic         found_o,
    output logic [W-1:0] idx_o
);

    // Walk offsets from farthest to nearest so the nearest hit is written last.
    always_comb begin
        found_o = 1'b0;
        idx_o   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_i[(int'(start_i) + i) % N]) begin
                found_o = 1'b1;
                idx_o   = W'((int'(start_i) + i) % N);
            end
        end
    end

endmodule

// File: rtl/fifo_read_interface_arbiter.sv
// N-to-1 round-robin merge of first-word-fall-through FIFO read ports into a
// single FWFT read port, with the source channel tagged on every word and a
// per-grant burst limit.
//   clock, reset    : clock; asynchronous active-low reset
//   up_rd_data      : head word of each upstream FIFO, channel i at [i*DATA_WIDTH +: DATA_WIDTH]
//   up_empty        : per-channel upstream empty
//   up_rd_en        : per-channel upstream pop (at most one bit high)
//   dn_rd_data      : held output word
//   dn_channel      : source channel of the held word
//   dn_empty        : no word held
//   dn_almost_empty : a word is held and every upstream FIFO is empty
//   dn_rd_en        : downstream pop
//
// state | meaning
// IDLE  | no grant active; next load scans from cur+1
// BURST | channel cur granted, burst_cnt words taken in this grant
module fifo_read_interface_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int NUM_CHANNELS = 4,
    parameter int BURST_MAX    = 16,
    parameter int CH_W         = ch_width(NUM_CHANNELS)
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] up_rd_data,
    input  logic [NUM_CHANNELS-1:0]          up_empty,
    output logic [NUM_CHANNELS-1:0]          up_rd_en,
    output logic [DATA_WIDTH-1:0]            dn_rd_data,
    output logic [CH_W-1:0]                  dn_channel,
    output logic                             dn_empty,
    output logic                             dn_almost_empty,
    input  logic                             dn_rd_en
);

    localparam int              BC_W      = $clog2(BURST_MAX + 1);
    localparam logic [CH_W-1:0] LAST_CH   = CH_W'(NUM_CHANNELS - 1);
    localparam logic [BC_W-1:0] BURST_LIM = BC_W'(BURST_MAX);

    logic                  valid_q, valid_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [CH_W-1:0]       chan_q, chan_d;
    logic [CH_W-1:0]       cur_q, cur_d;
    logic [BC_W-1:0]       burst_q, burst_d;
    arb_state_t            state_q, state_d;

    logic            pop;
    logic            load_slot;
    logic            cont_burst;
    logic            scan_found;
    logic [CH_W-1:0] scan_idx;
    logic [CH_W-1:0] scan_start;
    logic            sel_valid;
    logic [CH_W-1:0] sel;

    assign pop       = dn_rd_en & valid_q;
    assign load_slot = ~valid_q | pop;

    // cur itself is scanned last, so an expired burst with only cur pending
    // simply re-grants cur without a bubble.
    assign scan_start = (cur_q == LAST_CH) ? '0 : cur_q + 1'b1;
    assign cont_burst = (state_q == BURST) && !up_empty[cur_q] && (burst_q < BURST_LIM);

    rr_next_select #(
        .N (NUM_CHANNELS),
        .W (CH_W)
    ) u_rr_next_select (
        .req_i   (~up_empty),
        .start_i (scan_start),
        .found_o (scan_found),
        .idx_o   (scan_idx)
    );

    always_comb begin
        sel       = '0;
        sel_valid = 1'b0;
        up_rd_en  = '0;
        valid_d   = valid_q;
        data_d    = data_q;
        chan_d    = chan_q;
        cur_d     = cur_q;
        burst_d   = burst_q;
        state_d   = state_q;

        if (cont_burst) begin
            sel       = cur_q;
            sel_valid = 1'b1;
        end else if (scan_found) begin
            sel       = scan_idx;
            sel_valid = 1'b1;
        end

        // Arbitration only moves when the output slot can accept a word.
        if (load_slot) begin
            if (sel_valid) begin
                valid_d       = 1'b1;
                data_d        = up_rd_data[sel*DATA_WIDTH +: DATA_WIDTH];
                chan_d        = sel;
                cur_d         = sel;
                state_d       = BURST;
                burst_d       = cont_burst ? burst_q + 1'b1 : BC_W'(1);
                // Gated by reset so no upstream word is lost while in reset.
                up_rd_en[sel] = reset;
            end else begin
                state_d = IDLE;
                if (pop) begin
                    valid_d = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            chan_q  <= '0;
            cur_q   <= LAST_CH;
            burst_q <= '0;
            state_q <= IDLE;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            chan_q  <= chan_d;
            cur_q   <= cur_d;
            burst_q <= burst_d;
            state_q <= state_d;
        end
    end

    assign dn_rd_data      = data_q;
    assign dn_channel      = chan_q;
    assign dn_empty        = ~valid_q;
    assign dn_almost_empty = valid_q & (&up_empty);

endmodule
